// File: rtl/sejf_ctrl.sv
// Lock-sequencing controller for the safe: steps the digit comparator through the code,
// decides open/fail after the last step, and handles open time, entry timeout and lockout.
module sejf_ctrl #(
  parameter int NSTEPS        = 3,
  parameter int MAX_FAIL      = 3,
  parameter int OPEN_TICKS    = 10,
  parameter int LOCKOUT_TICKS = 30,
  parameter int ENTRY_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       eq,
  input  logic       tick,
  input  logic       close,
  output logic [1:0] sel,
  output logic       open,
  output logic       alarm,
  output logic [1:0] fail_cnt,
  output logic       wrong
);

  localparam int MAX_T = (OPEN_TICKS > LOCKOUT_TICKS)
                       ? ((OPEN_TICKS > ENTRY_TIMEOUT) ? OPEN_TICKS : ENTRY_TIMEOUT)
                       : ((LOCKOUT_TICKS > ENTRY_TIMEOUT) ? LOCKOUT_TICKS : ENTRY_TIMEOUT);
  localparam int CW = ($clog2(MAX_T + 1) > 5) ? $clog2(MAX_T + 1) : 5;

  localparam logic [1:0]    LAST_SEL   = 2'(NSTEPS - 1);
  localparam logic [1:0]    MAXF       = 2'(MAX_FAIL);
  localparam logic [CW-1:0] OPEN_LAST  = CW'(OPEN_TICKS - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCKOUT_TICKS - 1);
  localparam logic [CW-1:0] ENTRY_LAST = CW'(ENTRY_TIMEOUT - 1);

  typedef enum logic [1:0] {S_ENTRY, S_OPEN, S_LOCKOUT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sel_nxt, fail_nxt, fail_inc;
  logic          bad, bad_nxt, bad_f, wrong_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;

  // Mismatch verdict including the step being confirmed right now.
  assign bad_f    = bad | ~eq;
  assign fail_inc = fail_cnt + 2'd1;
  assign cnt_inc  = cnt + CW'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    sel_nxt   = sel;
    fail_nxt  = fail_cnt;
    bad_nxt   = bad;
    wrong_nxt = 1'b0;
    cnt_nxt   = cnt;

    case (state)
      S_ENTRY: begin
        if (enter) begin
          cnt_nxt = '0;
          if (sel != LAST_SEL) begin
            sel_nxt = sel + 2'd1;
            bad_nxt = bad_f;
          end else begin
            sel_nxt = '0;
            bad_nxt = 1'b0;
            if (!bad_f) begin
              state_nxt = S_OPEN;
              fail_nxt  = '0;
            end else begin
              wrong_nxt = 1'b1;
              fail_nxt  = fail_inc;
              if (fail_inc == MAXF) state_nxt = S_LOCKOUT;
            end
          end
        end else if (sel == '0) begin
          cnt_nxt = '0;
        end else if (tick) begin
          // Abandoned attempt: silently restart the sequence, not counted as a failure.
          if (cnt == ENTRY_LAST) begin
            sel_nxt = '0;
            bad_nxt = 1'b0;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      S_OPEN: begin
        if (close || (tick && cnt == OPEN_LAST)) begin
          state_nxt = S_ENTRY;
          sel_nxt   = '0;
          cnt_nxt   = '0;
        end else if (tick) begin
          cnt_nxt = cnt_inc;
        end
      end

      S_LOCKOUT: begin
        if (tick) begin
          if (cnt == LOCK_LAST) begin
            state_nxt = S_ENTRY;
            fail_nxt  = '0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      default: begin
        state_nxt = S_ENTRY;
        sel_nxt   = '0;
        bad_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // open/alarm are registered from the next state, so they follow the deciding edge directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_ENTRY;
      sel      <= '0;
      open     <= 1'b0;
      alarm    <= 1'b0;
      fail_cnt <= '0;
      wrong    <= 1'b0;
      bad      <= 1'b0;
      cnt      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      sel      <= sel_nxt;
      open     <= (state_nxt == S_OPEN);
      alarm    <= (state_nxt == S_LOCKOUT);
      fail_cnt <= fail_nxt;
      wrong    <= wrong_nxt;
      bad      <= bad_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sejf_ctrl.sv
// Directed bench for sejf_ctrl: reset, code entry, hidden mismatch, lockout,
// entry timeout with enter/tick collision, and close priority.
module tb_sejf_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter = 1'b0;
  logic       eq = 1'b0;
  logic       tick = 1'b0;
  logic       close = 1'b0;
  logic [1:0] sel;
  logic       open;
  logic       alarm;
  logic [1:0] fail_cnt;
  logic       wrong;

  int checks = 0;
  int errors = 0;

  sejf_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .enter    (enter),
    .eq       (eq),
    .tick     (tick),
    .close    (close),
    .sel      (sel),
    .open     (open),
    .alarm    (alarm),
    .fail_cnt (fail_cnt),
    .wrong    (wrong)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from a falling edge; returns on the next falling edge.
  task automatic step(input logic e, input logic q, input logic t, input logic c);
    enter = e; eq = q; tick = t; close = c;
    @(negedge clk);
    enter = 1'b0; eq = 1'b0; tick = 1'b0; close = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_sel",   32'(sel),      32'd0);
    check("reset_open",  32'(open),     32'd0);
    check("reset_alarm", 32'(alarm),    32'd0);
    check("reset_fail",  32'(fail_cnt), 32'd0);
    check("reset_wrong", 32'(wrong),    32'd0);

    // Asynchronous reset mid-sequence
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_sel1", 32'(sel), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_sel2", 32'(sel), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_sel",  32'(sel),      32'd0);
    check("async_open", 32'(open),     32'd0);
    check("async_fail", 32'(fail_cnt), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Correct code opens, OPEN_TICKS ticks relock
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ok_sel1", 32'(sel), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ok_sel2", 32'(sel), 32'd2);
    check("ok_open_early", 32'(open), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ok_sel0",  32'(sel),   32'd0);
    check("ok_open",  32'(open),  32'd1);
    check("ok_wrong", 32'(wrong), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("open_ignores_enter", 32'(sel), 32'd0);
    ticks(9);
    check("open_after9", 32'(open), 32'd1);
    ticks(1);
    check("open_after10", 32'(open), 32'd0);

    // Hidden mismatch on the first step
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("hid_sel1", 32'(sel), 32'd1);
    check("hid_wrong1", 32'(wrong), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("hid_sel2", 32'(sel), 32'd2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("hid_wrong", 32'(wrong),    32'd1);
    check("hid_fail",  32'(fail_cnt), 32'd1);
    check("hid_open",  32'(open),     32'd0);
    check("hid_sel0",  32'(sel),      32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("hid_wrong_pulse", 32'(wrong), 32'd0);

    // Two more failures (mismatch on the last step) -> lockout
    for (int i = 0; i < 3; i++) step(1'b1, (i != 2), 1'b0, 1'b0);
    check("fail2_cnt",   32'(fail_cnt), 32'd2);
    check("fail2_alarm", 32'(alarm),    32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, (i != 1), 1'b0, 1'b0);
    check("lock_alarm", 32'(alarm),    32'd1);
    check("lock_fail",  32'(fail_cnt), 32'd3);
    check("lock_wrong", 32'(wrong),    32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lock_ign_open",  32'(open),  32'd0);
    check("lock_ign_sel",   32'(sel),   32'd0);
    check("lock_ign_alarm", 32'(alarm), 32'd1);
    ticks(29);
    check("lock_after29", 32'(alarm), 32'd1);
    ticks(1);
    check("lock_after30_alarm", 32'(alarm),    32'd0);
    check("lock_after30_fail",  32'(fail_cnt), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_lock_open", 32'(open), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("close_relock", 32'(open), 32'd0);

    // Entry timeout is not a failure; enter wins over a coincident tick
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("to_fail_pre", 32'(fail_cnt), 32'd1);
    ticks(20);
    check("idle_sel0_no_count", 32'(sel), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(14);
    check("to_after14", 32'(sel), 32'd1);
    ticks(1);
    check("to_after15_sel",   32'(sel),      32'd0);
    check("to_after15_fail",  32'(fail_cnt), 32'd1);
    check("to_after15_wrong", 32'(wrong),    32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(14);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("collide_sel", 32'(sel), 32'd2);
    ticks(14);
    check("collide_cleared", 32'(sel), 32'd2);
    ticks(1);
    check("collide_timeout", 32'(sel), 32'd0);
    check("collide_fail",    32'(fail_cnt), 32'd1);

    // Close with the 9th tick in OPEN; close in ENTRY is ignored
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("cp_open", 32'(open), 32'd1);
    check("cp_fail", 32'(fail_cnt), 32'd0);
    ticks(8);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("cp_closed", 32'(open), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("entry_close_sel",   32'(sel),   32'd1);
    check("entry_close_open",  32'(open),  32'd0);
    check("entry_close_alarm", 32'(alarm), 32'd0);
    check("entry_close_wrong", 32'(wrong), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
